// File: rtl/rk_mem_arbiter_pkg.sv
// rtl/rk_mem_arbiter_pkg.sv - shared grant codes, FSM states and address width for the memory arbiter
package rk_mem_arbiter_pkg;

  localparam int ADDR_W = 18;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VID  = 2'd1;
  localparam logic [1:0] GNT_CPU  = 2'd2;
  localparam logic [1:0] GNT_LDR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rk_memarb_prio.sv
// rtl/rk_memarb_prio.sv - combinational winner picker: vid > cpu > ldr, cpu forced in when starved
module rk_memarb_prio
  import rk_mem_arbiter_pkg::*;
(
  input  logic       vid_req,
  input  logic       cpu_req,
  input  logic       ldr_req,
  input  logic       starve,
  output logic [1:0] win
);

  // Fixed priority with a starvation override for the CPU
  always_comb begin
    win = GNT_NONE;
    if (cpu_req && starve) begin
      win = GNT_CPU;
    end else if (vid_req) begin
      win = GNT_VID;
    end else if (cpu_req) begin
      win = GNT_CPU;
    end else if (ldr_req) begin
      win = GNT_LDR;
    end
  end

endmodule

// File: rtl/rk_mem_arbiter.sv
// rtl/rk_mem_arbiter.sv - fixed-slot SDRAM port arbiter for video/CPU (loader port via RK_MEMARB_LDR_EN)
module rk_mem_arbiter
  import rk_mem_arbiter_pkg::*;
#(
  parameter int SLOT_CLKS = 6,
  parameter int RD_LAT    = 4,
  parameter int VID_MAX   = 4
) (
  input  logic              clk50mhz,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [14:0]       vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [14:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
`ifdef RK_MEMARB_LDR_EN
  input  logic              ldr_req,
  input  logic [17:0]       ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ldr_ack,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_rd,
  output logic              mem_we_n,
  input  logic [15:0]       mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  arb_state_t state, state_nxt;
  logic [3:0] slot_cnt;
  logic [3:0] starve_cnt;
  logic       we_q;
  logic       ldr_req_i;
  logic [1:0] win;
  logic       slot_last;
  logic       unused_rdata_hi;

  assign unused_rdata_hi = ^mem_rdata[15:8];
  assign slot_last = (slot_cnt == 4'(SLOT_CLKS - 1));

`ifdef RK_MEMARB_LDR_EN
  assign ldr_req_i = ldr_req;
`else
  assign ldr_req_i = 1'b0;
`endif

  rk_memarb_prio u_prio (
    .vid_req (vid_req),
    .cpu_req (cpu_req),
    .ldr_req (ldr_req_i),
    .starve  (starve_cnt == 4'(VID_MAX)),
    .win     (win)
  );

  // State register
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobes; strobes follow the registered state so they stay glitch-free per slot
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_we_n  = 1'b1;
    vid_ack   = 1'b0;
    cpu_ack   = 1'b0;
`ifdef RK_MEMARB_LDR_EN
    ldr_ack   = 1'b0;
`endif
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (win != GNT_NONE) state_nxt = ST_SLOT;
      end
      ST_SLOT: begin
        mem_rd   = ~we_q;
        mem_we_n = ~we_q;
        if (slot_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        vid_ack = (grant == GNT_VID);
        cpu_ack = (grant == GNT_CPU);
`ifdef RK_MEMARB_LDR_EN
        ldr_ack = (grant == GNT_LDR);
`endif
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture in IDLE, slot counting and read-data sampling
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      grant     <= GNT_NONE;
      slot_cnt  <= 4'd0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      vid_data  <= 8'h00;
      cpu_rdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win != GNT_NONE) begin
            grant    <= win;
            slot_cnt <= 4'd0;
            case (win)
              GNT_VID: begin
                mem_addr <= {3'b000, vid_addr};
                we_q     <= 1'b0;
              end
              GNT_CPU: begin
                mem_addr <= {3'b000, cpu_addr};
                we_q     <= cpu_we;
                if (cpu_we) mem_wdata <= cpu_wdata;
              end
`ifdef RK_MEMARB_LDR_EN
              GNT_LDR: begin
                mem_addr  <= ldr_addr;
                we_q      <= 1'b1;
                mem_wdata <= ldr_wdata;
              end
`endif
              default: ;
            endcase
          end
        end
        ST_SLOT: begin
          slot_cnt <= slot_cnt + 4'd1;
          if ((slot_cnt == 4'(RD_LAT)) && !we_q) begin
            if (grant == GNT_VID) vid_data <= mem_rdata[7:0];
            if (grant == GNT_CPU) cpu_rdata <= mem_rdata[7:0];
          end
        end
        ST_DONE: begin
          grant <= GNT_NONE;
        end
        default: ;
      endcase
    end
  end

  // Count video grants that overtake a waiting CPU
  always_ff @(posedge clk50mhz) begin
    if (reset || !cpu_req) begin
      starve_cnt <= 4'd0;
    end else if (state == ST_IDLE) begin
      if (win == GNT_CPU) begin
        starve_cnt <= 4'd0;
      end else if ((win == GNT_VID) && (starve_cnt != 4'(VID_MAX))) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_rk_mem_arbiter.sv
// tb/tb_rk_mem_arbiter.sv - bench for rk_mem_arbiter (loader tests built with RK_MEMARB_LDR_EN)
module tb_rk_mem_arbiter;

  localparam int SLOT_CLKS = 6;
  localparam int RD_LAT    = 4;
  localparam int VID_MAX   = 4;

  logic        clk50mhz = 1'b0;
  logic        reset;
  logic        vid_req, cpu_req, cpu_we;
  logic [14:0] vid_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        vid_ack, cpu_ack;
  logic [7:0]  vid_data, cpu_rdata;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_we_n, busy;
  logic [15:0] mem_rdata;
  logic [1:0]  grant;
`ifdef RK_MEMARB_LDR_EN
  logic        ldr_req, ldr_ack;
  logic [17:0] ldr_addr;
  logic [7:0]  ldr_wdata;
`endif

  always #10 clk50mhz = ~clk50mhz;

  rk_mem_arbiter #(.SLOT_CLKS(SLOT_CLKS), .RD_LAT(RD_LAT), .VID_MAX(VID_MAX)) dut (
    .clk50mhz (clk50mhz),
    .reset    (reset),
    .vid_req  (vid_req),
    .vid_addr (vid_addr),
    .vid_ack  (vid_ack),
    .vid_data (vid_data),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
`ifdef RK_MEMARB_LDR_EN
    .ldr_req  (ldr_req),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_ack  (ldr_ack),
`endif
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd   (mem_rd),
    .mem_we_n (mem_we_n),
    .mem_rdata(mem_rdata),
    .grant    (grant),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction timeline model: m_pos is the cycle offset inside the current access,
  // 0..SLOT_CLKS-1 = strobe cycles, SLOT_CLKS = ack cycle, -1 = free.
  int         cyc = 0;
  bit         m_valid = 0;
  int         m_pos, m_owner, m_starve;
  bit         m_we;
  logic [17:0] m_addr;
  logic [7:0]  m_wdata, m_vdata, m_cdata;

  always @(posedge clk50mhz) begin : model
    int w;
    cyc++;
    if (reset) begin
      m_valid = 1; m_pos = -1; m_owner = 0; m_starve = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_vdata = 0; m_cdata = 0;
    end else if (m_valid) begin
      if (m_pos < 0) begin
        w = 0;
        if (cpu_req && m_starve == VID_MAX) w = 2;
        else if (vid_req) w = 1;
        else if (cpu_req) w = 2;
`ifdef RK_MEMARB_LDR_EN
        else if (ldr_req) w = 3;
`endif
        if (!cpu_req || w == 2) m_starve = 0;
        else if (w == 1 && m_starve < VID_MAX) m_starve++;
        if (w != 0) begin
          m_owner = w;
          m_pos = 0;
          if (w == 1) begin m_addr = {3'b000, vid_addr}; m_we = 0; end
          if (w == 2) begin
            m_addr = {3'b000, cpu_addr}; m_we = cpu_we;
            if (cpu_we) m_wdata = cpu_wdata;
          end
`ifdef RK_MEMARB_LDR_EN
          if (w == 3) begin m_addr = ldr_addr; m_we = 1; m_wdata = ldr_wdata; end
`endif
        end
      end else begin
        if (!cpu_req) m_starve = 0;
        if (m_pos == RD_LAT && !m_we) begin
          if (m_owner == 1) m_vdata = mem_rdata[7:0];
          if (m_owner == 2) m_cdata = mem_rdata[7:0];
        end
        if (m_pos == SLOT_CLKS) begin m_pos = -1; m_owner = 0; end
        else m_pos++;
      end
    end
  end

  // Compare every cycle once the model has seen a reset
  always @(negedge clk50mhz) begin : compare
    bit in_slot, in_done;
    if (m_valid) begin
      in_slot = (m_pos >= 0) && (m_pos < SLOT_CLKS);
      in_done = (m_pos == SLOT_CLKS);
      chk("mem_rd",    32'(mem_rd),    32'(in_slot && !m_we));
      chk("mem_we_n",  32'(mem_we_n),  32'(!(in_slot && m_we)));
      chk("vid_ack",   32'(vid_ack),   32'(in_done && m_owner == 1));
      chk("cpu_ack",   32'(cpu_ack),   32'(in_done && m_owner == 2));
`ifdef RK_MEMARB_LDR_EN
      chk("ldr_ack",   32'(ldr_ack),   32'(in_done && m_owner == 3));
`endif
      chk("grant",     32'(grant),     32'(m_owner));
      chk("busy",      32'(busy),      32'(m_pos >= 0));
      chk("mem_addr",  32'(mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("vid_data",  32'(vid_data),  32'(m_vdata));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cdata));
    end
  end

  // Requester side: ack log, auto-drop of requests on ack, random read data each cycle
  int   ack_who[$];
  int   ack_at[$];
  int   rd_cycles, wen_cycles;
  logic [7:0] last_wdata;
  bit   vid_hold = 0;

  task automatic tick();
    @(negedge clk50mhz);
    #1;
    if (mem_rd) rd_cycles++;
    if (!mem_we_n) begin wen_cycles++; last_wdata = mem_wdata; end
    if (vid_ack) begin ack_who.push_back(1); ack_at.push_back(cyc); if (!vid_hold) vid_req = 0; end
    if (cpu_ack) begin ack_who.push_back(2); ack_at.push_back(cyc); cpu_req = 0; end
`ifdef RK_MEMARB_LDR_EN
    if (ldr_ack) begin ack_who.push_back(3); ack_at.push_back(cyc); ldr_req = 0; end
`endif
    mem_rdata = 16'($urandom);
  endtask

  function automatic bit pending();
    bit p;
    p = vid_req || cpu_req || busy;
`ifdef RK_MEMARB_LDR_EN
    p = p || ldr_req;
`endif
    return p;
  endfunction

  task automatic drain(input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin tick(); n++; end
    chk("drain_bound", 32'(n < max), 32'd1);
  endtask

  task automatic start_test();
    ack_who.delete(); ack_at.delete();
    rd_cycles = 0; wen_cycles = 0; last_wdata = 8'h00;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    logic [7:0] saved;
    int exp_seq[6];
    int n;
    exp_seq = '{1, 1, 1, 1, 2, 1};
    reset = 1; vid_req = 0; cpu_req = 0; cpu_we = 0;
    vid_addr = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0;
`ifdef RK_MEMARB_LDR_EN
    ldr_req = 0; ldr_addr = 0; ldr_wdata = 0;
`endif
    repeat (3) tick();
    chk("rst_grant",    32'(grant),     32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_mem_rd",   32'(mem_rd),    32'd0);
    chk("rst_mem_we_n", 32'(mem_we_n),  32'd1);
    chk("rst_mem_addr", 32'(mem_addr),  32'd0);
    chk("rst_vid_data", 32'(vid_data),  32'd0);
    chk("rst_cpu_rdata",32'(cpu_rdata), 32'd0);
    reset = 0;
    repeat (2) tick();

    // 1: single video read, 0xA5 presented only in the RD_LAT slot cycle
    start_test();
    vid_addr = 15'h1234; vid_req = 1; t0 = cyc;
    repeat (5) tick();
    mem_rdata = 16'h00A5;
    drain(40);
    chk("t1_acks",     32'(ack_who.size()), 32'd1);
    chk("t1_who",      32'(ack_who[0]), 32'd1);
    chk("t1_latency",  32'(ack_at[0] - t0 + 1), 32'd8);
    chk("t1_mem_addr", 32'(mem_addr), 32'h01234);
    chk("t1_rd_cyc",   32'(rd_cycles), 32'd6);
    chk("t1_vid_data", 32'(vid_data), 32'hA5);

    // 2: CPU write 0x3C to 0x7FFF
    start_test();
    saved = cpu_rdata;
    cpu_we = 1; cpu_addr = 15'h7FFF; cpu_wdata = 8'h3C; cpu_req = 1;
    drain(40);
    chk("t2_acks",      32'(ack_who.size()), 32'd1);
    chk("t2_who",       32'(ack_who[0]), 32'd2);
    chk("t2_we_cyc",    32'(wen_cycles), 32'd6);
    chk("t2_rd_cyc",    32'(rd_cycles), 32'd0);
    chk("t2_wdata",     32'(last_wdata), 32'h3C);
    chk("t2_mem_addr",  32'(mem_addr), 32'h07FFF);
    chk("t2_cpu_rdata", 32'(cpu_rdata), 32'(saved));

    // 3: simultaneous video and CPU read
    start_test();
    cpu_we = 0; cpu_addr = 15'h0200; vid_addr = 15'h0100;
    vid_req = 1; cpu_req = 1;
    drain(60);
    chk("t3_acks", 32'(ack_who.size()), 32'd2);
    chk("t3_first", 32'(ack_who[0]), 32'd1);
    chk("t3_second", 32'(ack_who[1]), 32'd2);
    chk("t3_spacing", 32'(ack_at[1] - ack_at[0]), 32'd8);

    // 4: video held continuously, CPU waits VID_MAX grants
    start_test();
    vid_hold = 1; vid_req = 1; vid_addr = 15'h0777;
    cpu_we = 0; cpu_addr = 15'h0333; cpu_req = 1;
    n = 0;
    while (ack_who.size() < 6 && n < 100) begin tick(); n++; end
    chk("t4_bound", 32'(n < 100), 32'd1);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_seq%0d", i), 32'(ack_who[i]), 32'(exp_seq[i]));
    vid_hold = 0;
    drain(60);

    // 5: reset during slot cycle 2 of a CPU read
    start_test();
    cpu_we = 0; cpu_addr = 15'h0055; cpu_req = 1;
    repeat (3) tick();
    chk("t5_busy_before", 32'(busy), 32'd1);
    reset = 1;
    tick();
    chk("t5_mem_rd", 32'(mem_rd), 32'd0);
    chk("t5_busy",   32'(busy),   32'd0);
    chk("t5_grant",  32'(grant),  32'd0);
    cpu_req = 0; reset = 0;
    repeat (12) tick();
    chk("t5_no_ack", 32'(ack_who.size()), 32'd0);

`ifdef RK_MEMARB_LDR_EN
    // 6: loader write alone, then loader and CPU together
    start_test();
    ldr_addr = 18'h2ABCD; ldr_wdata = 8'h55; ldr_req = 1;
    drain(40);
    chk("t6_who",      32'(ack_who[0]), 32'd3);
    chk("t6_mem_addr", 32'(mem_addr), 32'h2ABCD);
    chk("t6_we_cyc",   32'(wen_cycles), 32'd6);
    chk("t6_wdata",    32'(last_wdata), 32'h55);
    start_test();
    ldr_req = 1; cpu_we = 1; cpu_addr = 15'h0042; cpu_wdata = 8'h99; cpu_req = 1;
    drain(60);
    chk("t6_first",  32'(ack_who[0]), 32'd2);
    chk("t6_second", 32'(ack_who[1]), 32'd3);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
